// File: rtl/vram_arb_pkg.sv
// Shared definitions for the video/work RAM arbiter: state encoding and default widths.
package vram_arb_pkg;

  localparam int AW_DEF    = 11;
  localparam int DW_DEF    = 8;
  localparam int OVR_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DSP_RD  = 3'd1,
    ST_DSP_CAP = 3'd2,
    ST_CPU_RD  = 3'd3,
    ST_CPU_CAP = 3'd4,
    ST_CPU_WR  = 3'd5
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous enable and asynchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_count <= '0;
    end else if (i_en && (o_count != {W{1'b1}})) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port RAM arbiter: display fetch has priority, CPU is served through req/ack,
// and a last-grant flag alternates the two when both are waiting.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int OVR_W = OVR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_dsp_req,
  input  logic [AW-1:0]    i_dsp_addr,
  output logic [DW-1:0]    o_dsp_data,
  output logic             o_dsp_valid,
  input  logic             i_cpu_req,
  input  logic             i_cpu_we,
  input  logic [AW-1:0]    i_cpu_addr,
  input  logic [DW-1:0]    i_cpu_wdata,
  output logic [DW-1:0]    o_cpu_rdata,
  output logic             o_cpu_ack,
  output logic [AW-1:0]    o_ram_addr,
  output logic             o_ram_we,
  output logic [DW-1:0]    o_ram_wdata,
  input  logic [DW-1:0]    i_ram_rdata,
  output logic [OVR_W-1:0] o_dsp_overrun,
  output logic [2:0]       o_state
);

  // Handshake: the CPU holds i_cpu_req high until it sees o_cpu_ack; o_cpu_ack is a
  // one-cycle pulse, and the req sample taken during the ack cycle is discarded so a
  // requester that drops req on the following cycle never gets a second grant.

  arb_state_e     r_state;
  logic           r_dsp_pend;
  logic [AW-1:0]  r_dsp_addr_q;
  logic           r_last_dsp;
  logic           r_cpu_req;

  logic w_idle;
  logic w_cpu_elig;
  logic w_grant_dsp;
  logic w_grant_cpu;
  logic w_overrun;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_cpu_elig  = r_cpu_req & ~o_cpu_ack;
  assign w_grant_dsp = w_idle & r_dsp_pend & (~w_cpu_elig | ~r_last_dsp);
  assign w_grant_cpu = w_idle & w_cpu_elig & ~w_grant_dsp;
  // A request landing in the grant cycle replaces the one being served, not a lost one.
  assign w_overrun   = i_dsp_req & r_dsp_pend & ~w_grant_dsp;
  assign o_state     = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dsp_pend   <= 1'b0;
      r_dsp_addr_q <= '0;
      r_cpu_req    <= 1'b0;
    end else begin
      r_cpu_req <= i_cpu_req & ~o_cpu_ack;
      if (i_dsp_req) begin
        r_dsp_pend   <= 1'b1;
        r_dsp_addr_q <= i_dsp_addr;
      end else if (w_grant_dsp) begin
        r_dsp_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_dsp  <= 1'b0;
      o_dsp_data  <= '0;
      o_dsp_valid <= 1'b0;
      o_cpu_rdata <= '0;
      o_cpu_ack   <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_we    <= 1'b0;
      o_ram_wdata <= '0;
    end else begin
      o_ram_we    <= 1'b0;
      o_dsp_valid <= 1'b0;
      o_cpu_ack   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_dsp) begin
            r_state    <= ST_DSP_RD;
            o_ram_addr <= r_dsp_addr_q;
            r_last_dsp <= 1'b1;
          end else if (w_grant_cpu) begin
            o_ram_addr <= i_cpu_addr;
            r_last_dsp <= 1'b0;
            if (i_cpu_we) begin
              r_state     <= ST_CPU_WR;
              o_ram_we    <= 1'b1;
              o_ram_wdata <= i_cpu_wdata;
            end else begin
              r_state <= ST_CPU_RD;
            end
          end
        end
        ST_DSP_RD: r_state <= ST_DSP_CAP;
        ST_DSP_CAP: begin
          o_dsp_data  <= i_ram_rdata;
          o_dsp_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_CPU_RD: r_state <= ST_CPU_CAP;
        ST_CPU_CAP: begin
          o_cpu_rdata <= i_ram_rdata;
          o_cpu_ack   <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_CPU_WR: begin
          o_cpu_ack <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(OVR_W)) u_overrun (
    .clk     (clk),
    .rst     (reset),
    .i_en    (w_overrun),
    .o_count (o_dsp_overrun)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for single transfers plus
// hand-built sequences for reset abort, alternation, overrun and ack hold-off.
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        dsp_req;
  logic [10:0] dsp_addr;
  logic [7:0]  dsp_data;
  logic        dsp_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  dsp_overrun;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:2047];

  vram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_dsp_req    (dsp_req),
    .i_dsp_addr   (dsp_addr),
    .o_dsp_data   (dsp_data),
    .o_dsp_valid  (dsp_valid),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_ack    (cpu_ack),
    .o_ram_addr   (ram_addr),
    .o_ram_we     (ram_we),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata),
    .o_dsp_overrun(dsp_overrun),
    .o_state      (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read RAM model, preloaded while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      mem[11'h405] <= 8'hA7;
      mem[11'h010] <= 8'h10;
      mem[11'h020] <= 8'h2F;
      mem[11'h100] <= 8'h11;
      mem[11'h200] <= 8'h22;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- helpers / drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [10:0] a, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output int we_cyc,
                          output logic [10:0] addr2, output logic [7:0] wd_seen);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0; we_cyc = 0; addr2 = '0; wd_seen = '0;
    do begin
      step();
      lat++;
      if (lat == 2) addr2 = ram_addr;
      if (ram_we) begin
        we_cyc++;
        wd_seen = ram_wdata;
      end
    end while (!cpu_ack && lat < 20);
    rd = cpu_rdata;
    cpu_req = 1'b0;
    step();
    step();
  endtask

  task automatic dsp_fetch(input logic [10:0] a, output int lat, output logic [7:0] d,
                           output logic [10:0] addr2, output logic v_after,
                           output logic [7:0] d_after);
    dsp_req = 1'b1; dsp_addr = a; lat = 0; addr2 = '0;
    do begin
      step();
      lat++;
      dsp_req = 1'b0;
      if (lat == 2) addr2 = ram_addr;
    end while (!dsp_valid && lat < 20);
    d = dsp_data;
    step();
    v_after = dsp_valid;
    d_after = dsp_data;
    step();
  endtask

  function automatic logic [63:0] all_outs();
    return {15'd0, state, ram_addr, ram_we, ram_wdata, cpu_rdata, cpu_ack,
            dsp_data, dsp_valid, dsp_overrun};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int          kind;      // 0 = CPU write, 1 = CPU read, 2 = display fetch
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat;
    int          we_cyc;
    logic [7:0]  rd;
    logic [10:0] a2;
    logic [7:0]  wd_seen;
    logic        v_after;
    logic [7:0]  d_after;
    int          ack_cyc, v1_cyc, v2_cyc, nval, nwe, nack, we2_cyc;
    logic [7:0]  v1_dat, v2_dat;

    vecs[0] = '{0, 11'h012, 8'h3C, 8'h00, 3};
    vecs[1] = '{1, 11'h012, 8'h00, 8'h3C, 4};
    vecs[2] = '{2, 11'h405, 8'h00, 8'hA7, 4};
    vecs[3] = '{0, 11'h7FF, 8'h5A, 8'h00, 3};
    vecs[4] = '{1, 11'h7FF, 8'h00, 8'h5A, 4};
    vecs[5] = '{0, 11'h000, 8'hFF, 8'h00, 3};
    vecs[6] = '{1, 11'h000, 8'h00, 8'hFF, 4};
    vecs[7] = '{2, 11'h7FF, 8'h00, 8'h5A, 4};
    vecs[8] = '{2, 11'h012, 8'h00, 8'h3C, 4};
    vecs[9] = '{1, 11'h405, 8'h00, 8'hA7, 4};

    reset = 1'b1;
    dsp_req = 1'b0; dsp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_outputs", all_outs(), 64'd0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].kind == 2) begin
        dsp_fetch(vecs[i].addr, lat, rd, a2, v_after, d_after);
        check($sformatf("v%0d_dsp_lat", i), lat, vecs[i].exp_lat);
        check($sformatf("v%0d_dsp_data", i), rd, vecs[i].exp_data);
        check($sformatf("v%0d_dsp_ramaddr", i), a2, vecs[i].addr);
        check($sformatf("v%0d_dsp_pulse", i), v_after, 1'b0);
        check($sformatf("v%0d_dsp_hold", i), d_after, vecs[i].exp_data);
      end else begin
        cpu_xfer(vecs[i].kind == 0, vecs[i].addr, vecs[i].wdata, lat, rd, we_cyc, a2, wd_seen);
        check($sformatf("v%0d_cpu_lat", i), lat, vecs[i].exp_lat);
        check($sformatf("v%0d_cpu_ramaddr", i), a2, vecs[i].addr);
        if (vecs[i].kind == 0) begin
          check($sformatf("v%0d_we_cycles", i), we_cyc, 1);
          check($sformatf("v%0d_wdata", i), wd_seen, vecs[i].wdata);
        end else begin
          check($sformatf("v%0d_we_cycles", i), we_cyc, 0);
          check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_data);
        end
      end
    end

    // Reset in the middle of a CPU write: ram_we must drop asynchronously.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h3AA; cpu_wdata = 8'h99;
    step();
    step();
    check("rst_we_before", ram_we, 1'b1);
    #2 reset = 1'b1;
    cpu_req = 1'b0;
    #1 check("rst_we_async_drop", ram_we, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    nack = 0; nval = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (cpu_ack) nack++;
      if (dsp_valid) nval++;
    end
    check("rst_no_ack", nack, 0);
    check("rst_no_valid", nval, 0);
    check("rst_outputs_zero", all_outs(), 64'd0);

    // CPU held continuously, display every 6 cycles: grants alternate, nothing lost.
    cpu_we = 1'b0; cpu_addr = 11'h012; cpu_req = 1'b1;
    for (int c = 0; c <= 37; c++) begin
      check($sformatf("alt_valid_c%0d", c), dsp_valid,
            (c >= 4 && c <= 34 && ((c - 4) % 6) == 0) ? 1'b1 : 1'b0);
      check($sformatf("alt_ack_c%0d", c), cpu_ack,
            (c >= 7 && ((c - 7) % 6) == 0) ? 1'b1 : 1'b0);
      dsp_req = (c <= 30 && (c % 6) == 0) ? 1'b1 : 1'b0;
      dsp_addr = 11'h100 + 11'(c);
      if (c == 37) cpu_req = 1'b0;
      step();
    end
    dsp_req = 1'b0;
    repeat (3) step();
    check("alt_overrun", dsp_overrun, 8'd0);

    // Both waiting right after a display grant: the CPU must go first.
    cpu_req = 1'b1; cpu_addr = 11'h012;
    dsp_req = 1'b1; dsp_addr = 11'h100;
    step();
    dsp_req = 1'b0;
    step();
    dsp_req = 1'b1; dsp_addr = 11'h200;
    step();
    dsp_req = 1'b0;
    ack_cyc = -1; v1_cyc = -1; v2_cyc = -1; v1_dat = '0; v2_dat = '0;
    for (int g = 3; g <= 14; g++) begin
      if (dsp_valid) begin
        if (v1_cyc < 0) begin v1_cyc = g; v1_dat = dsp_data; end
        else begin v2_cyc = g; v2_dat = dsp_data; end
      end
      if (cpu_ack) begin ack_cyc = g; cpu_req = 1'b0; end
      step();
    end
    check("guard_v1_cycle", v1_cyc, 4);
    check("guard_v1_data", v1_dat, 8'h11);
    check("guard_ack_cycle", ack_cyc, 7);
    check("guard_v2_cycle", v2_cyc, 10);
    check("guard_v2_data", v2_dat, 8'h22);
    check("guard_overrun", dsp_overrun, 8'd0);

    // Two display requests during a CPU read: the newer address wins, one overrun.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h012;
    step();
    step();
    dsp_req = 1'b1; dsp_addr = 11'h010;
    step();
    dsp_addr = 11'h020;
    step();
    dsp_req = 1'b0;
    ack_cyc = -1; v1_cyc = -1; v1_dat = '0; nval = 0; rd = '0;
    for (int o = 4; o <= 14; o++) begin
      if (dsp_valid) begin nval++; v1_cyc = o; v1_dat = dsp_data; end
      if (cpu_ack) begin ack_cyc = o; rd = cpu_rdata; cpu_req = 1'b0; end
      step();
    end
    check("ovr_ack_cycle", ack_cyc, 4);
    check("ovr_cpu_rdata", rd, 8'h3C);
    check("ovr_valid_count", nval, 1);
    check("ovr_valid_cycle", v1_cyc, 7);
    check("ovr_newer_data", v1_dat, 8'h2F);
    check("ovr_count_one", dsp_overrun, 8'd1);

    // Requester drops req one cycle after ack: no second grant.
    cpu_we = 1'b1; cpu_addr = 11'h055; cpu_wdata = 8'h66;
    nwe = 0; nack = 0;
    for (int h = 0; h <= 12; h++) begin
      if (ram_we) nwe++;
      if (cpu_ack) nack++;
      cpu_req = (h < 4) ? 1'b1 : 1'b0;
      step();
    end
    check("hold1_we_count", nwe, 1);
    check("hold1_ack_count", nack, 1);

    // Req still high the cycle after ack: a fresh access follows.
    nwe = 0; nack = 0; we2_cyc = -1; ack_cyc = -1;
    for (int h = 0; h <= 12; h++) begin
      if (ram_we) begin nwe++; we2_cyc = h; end
      if (cpu_ack) begin nack++; ack_cyc = h; end
      cpu_req = (h < 7) ? 1'b1 : 1'b0;
      step();
    end
    check("hold2_we_count", nwe, 2);
    check("hold2_ack_count", nack, 2);
    check("hold2_second_we_cycle", we2_cyc, 6);
    check("hold2_second_ack_cycle", ack_cyc, 7);
    check("hold_overrun_kept", dsp_overrun, 8'd1);

    // Continuous display requests: far more than 255 overruns, counter saturates.
    dsp_req = 1'b1; dsp_addr = 11'h010;
    repeat (500) step();
    dsp_req = 1'b0;
    repeat (8) step();
    check("ovr_saturate", dsp_overrun, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
